// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot row drive, synchronized column sense,
// press/release debounce and a one-cycle strobe carrying the accepted key code.
module keypad_scanner #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_MAX    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    colsMeta_q, colsSync_q;
  logic [3:0]    rows_q, rows_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_q, key_d;
  logic          keyValid_q, keyValid_d;
  logic          keyHeld_q, keyHeld_d;

  logic [3:0] rowsNext;
  logic       colsOneHot;

  function automatic logic [1:0] ohIdx(input logic [3:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Index is {row, col}; row4 carries the *, 0, #, D keys.
  function automatic logic [3:0] keyCode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'd10;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = 4'd11;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = 4'd12;
      4'd12:   code = 4'd14;
      4'd13:   code = 4'd0;
      4'd14:   code = 4'd15;
      default: code = 4'd13;
    endcase
    return code;
  endfunction

  assign rowsNext   = {rows_q[2:0], rows_q[3]};
  assign colsOneHot = (colsSync_q != 4'b0000) && ((colsSync_q & (colsSync_q - 4'd1)) == 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      colsMeta_q <= 4'b0000;
      colsSync_q <= 4'b0000;
    end else begin
      colsMeta_q <= cols;
      colsSync_q <= colsMeta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    dwell_d    = dwell_q;
    count_d    = count_q;
    cand_d     = cand_q;
    key_d      = key_q;
    keyValid_d = 1'b0;
    keyHeld_d  = keyHeld_q;
    case (state_q)
      ST_SCAN: begin
        // Only the last dwell cycle is trusted; earlier ones cover settling and sync latency.
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (colsOneHot) begin
            cand_d  = colsSync_q;
            count_d = CW'(1);
            state_d = ST_DEBOUNCE;
          end else begin
            rows_d = rowsNext;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (count_q == DEB_MAX) begin
          key_d      = keyCode(ohIdx(rows_q), ohIdx(cand_q));
          keyValid_d = 1'b1;
          keyHeld_d  = 1'b1;
          count_d    = '0;
          state_d    = ST_HELD;
        end else if (colsSync_q == cand_q) begin
          count_d = count_q + CW'(1);
        end else begin
          rows_d  = rowsNext;
          count_d = '0;
          state_d = ST_SCAN;
        end
      end
      ST_HELD: begin
        if (colsSync_q != 4'b0000) begin
          count_d = '0;
        end else if (count_q == DEB_LAST) begin
          keyHeld_d = 1'b0;
          count_d   = '0;
          rows_d    = rowsNext;
          state_d   = ST_SCAN;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_SCAN;
        rows_d  = 4'b0001;
        dwell_d = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      rows_q     <= 4'b0001;
      dwell_q    <= '0;
      count_q    <= '0;
      cand_q     <= 4'b0000;
      key_q      <= 4'b0000;
      keyValid_q <= 1'b0;
      keyHeld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      dwell_q    <= dwell_d;
      count_q    <= count_d;
      cand_q     <= cand_d;
      key_q      <= key_d;
      keyValid_q <= keyValid_d;
      keyHeld_q  <= keyHeld_d;
    end
  end

  assign rows      = rows_q;
  assign key       = key_q;
  assign key_valid = keyValid_q;
  assign key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model ties cols to the driven row; expected
// codes come from the key map table and expected timing from dwell + debounce lengths.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int LATENCY  = SCAN_DIV + DEB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .cols(cols), .rows(rows),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  int keyMap[4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  logic       pressed  = 1'b0;
  logic       ghost    = 1'b0;
  int         pRow     = 0;
  int         pCol     = 0;
  logic [3:0] ghostPat = 4'b0000;

  int checks = 0;
  int passes = 0;

  // Keypad: the pressed switch connects its row line to its column line.
  always_comb begin
    cols = 4'b0000;
    if (ghost) begin
      if (rows == 4'b0001) cols = ghostPat;
    end else if (pressed && rows[pRow]) begin
      cols = 4'b0001 << pCol;
    end
  end

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  int         validCount   = 0;
  int         keyChangeErr = 0;
  int         consecErr    = 0;
  logic [3:0] prevKey;
  logic       prevValid    = 1'b0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      prevKey   = key;
      prevValid = 1'b0;
    end else begin
      if (key_valid === 1'b1) validCount++;
      if (key !== prevKey && key_valid !== 1'b1) keyChangeErr++;
      if (key_valid === 1'b1 && prevValid === 1'b1) consecErr++;
      prevKey   = key;
      prevValid = key_valid;
    end
  end

  // Presses the key while its row is idle, returns at the first negedge its row is driven.
  task automatic armKey(input int r, input int c, output logic ok);
    int n;
    ghost = 1'b0;
    pRow  = r;
    pCol  = c;
    n = 0;
    while (rows[r] !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    pressed = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rows[r] !== 1'b1 && n < 60);
    ok = (rows[r] === 1'b1);
  endtask

  task automatic test_reset();
    logic [3:0] expRow;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rows !== 4'b0001) $display("[TB] FAIL reset_rows: got %b expected 0001", rows); else passes++;
    checks++; if (key !== 4'd0) $display("[TB] FAIL reset_key: got %0d expected 0", key); else passes++;
    checks++; if (key_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", key_valid); else passes++;
    checks++; if (key_held !== 1'b0) $display("[TB] FAIL reset_held: got %b expected 0", key_held); else passes++;
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      expRow = 4'b0001 << (((i + 1) / SCAN_DIV) % 4);
      checks++;
      if (rows !== expRow) $display("[TB] FAIL reset_rotate[%0d]: got %b expected %b", i, rows, expRow);
      else passes++;
    end
  endtask

  task automatic test_press(input int r, input int c, input int hold, input string tag);
    logic       ok;
    logic       early;
    int         startCount;
    logic [3:0] expKey;
    logic [3:0] expRow;
    expKey = 4'(keyMap[r][c]);
    expRow = 4'b0001 << r;
    armKey(r, c, ok);
    checks++;
    if (!ok) begin
      $display("[TB] FAIL %s row_reach: row %0d never driven, rows=%b", tag, r, rows);
      pressed = 1'b0;
      return;
    end
    passes++;
    startCount = validCount;
    early = 1'b0;
    repeat (LATENCY - 1) begin
      @(negedge clk);
      if (key_valid !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) $display("[TB] FAIL %s early_strobe: got 1 expected 0", tag); else passes++;
    @(negedge clk);
    checks++; if (key_valid !== 1'b1) $display("[TB] FAIL %s strobe_latency: got %b expected 1", tag, key_valid); else passes++;
    checks++; if (key !== expKey) $display("[TB] FAIL %s key_code: got %0d expected %0d", tag, key, expKey); else passes++;
    checks++; if (key_held !== 1'b1) $display("[TB] FAIL %s held_set: got %b expected 1", tag, key_held); else passes++;
    repeat (hold) @(negedge clk);
    #1;
    checks++; if (rows !== expRow) $display("[TB] FAIL %s rows_frozen: got %b expected %b", tag, rows, expRow); else passes++;
    checks++;
    if (validCount - startCount != 1) $display("[TB] FAIL %s single_strobe: got %0d expected 1", tag, validCount - startCount);
    else passes++;
    pressed = 1'b0;
    repeat (DEB + 1) @(negedge clk);
    checks++; if (key_held !== 1'b1) $display("[TB] FAIL %s held_early_drop: got %b expected 1", tag, key_held); else passes++;
    @(negedge clk);
    checks++; if (key_held !== 1'b0) $display("[TB] FAIL %s held_clear: got %b expected 0", tag, key_held); else passes++;
    checks++; if (rows !== rotl(expRow)) $display("[TB] FAIL %s scan_resume: got %b expected %b", tag, rows, rotl(expRow)); else passes++;
  endtask

  task automatic test_press_five();
    test_press(1, 1, 100, "press5");
  endtask

  task automatic test_press_random();
    int r;
    int c;
    for (int i = 0; i < 4; i++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      test_press(r, c, $urandom_range(15, 40), $sformatf("rand%0d_r%0dc%0d", i, r, c));
    end
  endtask

  task automatic test_bounce();
    logic ok;
    int   startCount;
    int   n;
    armKey(0, 3, ok);
    checks++;
    if (!ok) begin
      $display("[TB] FAIL bounce_row_reach: rows=%b", rows);
      pressed = 1'b0;
      return;
    end
    passes++;
    startCount = validCount;
    repeat (3) @(negedge clk);
    pressed = 1'b0;
    repeat (2) @(negedge clk);
    pressed = 1'b1;
    @(negedge clk);
    checks++; if (rows !== 4'b0010) $display("[TB] FAIL bounce_abort: rows %b expected 0010", rows); else passes++;
    n = 0;
    while (key_valid !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++; if (key_valid !== 1'b1) $display("[TB] FAIL bounce_strobe: got %b expected 1", key_valid); else passes++;
    checks++; if (key !== 4'd10) $display("[TB] FAIL bounce_key: got %0d expected 10", key); else passes++;
    #1;
    checks++;
    if (validCount - startCount != 1) $display("[TB] FAIL bounce_single: got %0d strobes expected 1", validCount - startCount);
    else passes++;
    pressed = 1'b0;
    n = 0;
    while (key_held !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++; if (key_held !== 1'b0) $display("[TB] FAIL bounce_release: held %b expected 0", key_held); else passes++;
  endtask

  task automatic test_ghost();
    logic [3:0] prev;
    logic [3:0] pat;
    int         changes;
    int         bad;
    int         startCount;
    pressed = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) pat = 4'b0011;
      else begin
        do pat = 4'($urandom_range(0, 15)); while ($countones(pat) < 2);
      end
      ghostPat = pat;
      ghost = 1'b1;
      startCount = validCount;
      prev = rows;
      changes = 0;
      bad = 0;
      repeat (10 * SCAN_DIV) begin
        @(negedge clk);
        if (rows !== prev) begin
          changes++;
          if (rows !== rotl(prev)) bad++;
          prev = rows;
        end
      end
      #1;
      checks++; if (changes != 10) $display("[TB] FAIL ghost%0d_rotations: got %0d expected 10", k, changes); else passes++;
      checks++; if (bad != 0) $display("[TB] FAIL ghost%0d_order: got %0d bad steps expected 0", k, bad); else passes++;
      checks++;
      if (validCount - startCount != 0) $display("[TB] FAIL ghost%0d_strobe: got %0d expected 0", k, validCount - startCount);
      else passes++;
    end
    ghost = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_row4_map();
    for (int c = 0; c < 4; c++) test_press(3, c, $urandom_range(5, 20), $sformatf("row4_col%0d", c + 1));
  endtask

  task automatic test_reset_mid_debounce();
    logic ok;
    int   startCount;
    armKey($urandom_range(0, 3), $urandom_range(0, 3), ok);
    checks++;
    if (!ok) begin
      $display("[TB] FAIL middeb_row_reach: rows=%b", rows);
      pressed = 1'b0;
      return;
    end
    passes++;
    // Sample lands SCAN_DIV cycles after row arrival; four further stable cycles bring the count to 5.
    repeat (SCAN_DIV + 4) @(negedge clk);
    rst = 1'b1;
    pressed = 1'b0;
    @(negedge clk);
    checks++; if (rows !== 4'b0001) $display("[TB] FAIL middeb_rows: got %b expected 0001", rows); else passes++;
    checks++; if (key !== 4'd0) $display("[TB] FAIL middeb_key: got %0d expected 0", key); else passes++;
    checks++; if (key_valid !== 1'b0) $display("[TB] FAIL middeb_valid: got %b expected 0", key_valid); else passes++;
    checks++; if (key_held !== 1'b0) $display("[TB] FAIL middeb_held: got %b expected 0", key_held); else passes++;
    #1 rst = 1'b0;
    startCount = validCount;
    repeat (30) @(negedge clk);
    #1;
    checks++;
    if (validCount - startCount != 0) $display("[TB] FAIL middeb_no_strobe: got %0d expected 0", validCount - startCount);
    else passes++;
    checks++; if (key !== 4'd0) $display("[TB] FAIL middeb_key_after: got %0d expected 0", key); else passes++;
  endtask

  task automatic test_invariants();
    checks++; if (keyChangeErr != 0) $display("[TB] FAIL key_change_without_strobe: got %0d expected 0", keyChangeErr); else passes++;
    checks++; if (consecErr != 0) $display("[TB] FAIL back_to_back_strobe: got %0d expected 0", consecErr); else passes++;
  endtask

  initial begin
    test_reset();
    test_press_five();
    test_bounce();
    test_ghost();
    test_row4_map();
    test_press_random();
    test_reset_mid_debounce();
    test_invariants();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
